ps2_frame_rx: RTL and testbench

Parametrised PS/2 device-to-host frame receiver; successor to the bare 11-bit keyboard shift register.
- Synchronises raw ps2_clk/ps2_dat and shifts on ps2_clk falling edges.
- Checks start, parity and stop bits; recovers from stalled frames via a watchdog.
- Presents each good data byte on a valid/ready interface to the keyboard decoder.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync_edge.sv | 32 +++
 rtl/ps2_frame_rx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = PS2_DATA_BITS + 3;

    function automatic int frame_bits(input int data_bits);
        return data_bits + 3;
    endfunction

    // True when the data bits plus the received parity bit match the parity sense.
    function automatic logic parity_ok(
        input logic [31:0] data,
        input logic        par,
        input logic        odd
    );
        return ((^data) ^ par) == odd;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for one PS/2 line with a registered falling-edge pulse.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_fall;

    // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
            r_fall <= r_prev & ~r_sync[STAGES-1];
        end
    end

    assign o_level = r_prev;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start/parity/stop checks, watchdog,
// and a single holding register on a valid/ready interface.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int DATA_BITS      = PS2_DATA_BITS,
    parameter int SYNC_STAGES    = 2,
    parameter int ODD_PARITY     = 1,
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW  = $clog2(frame_bits(DATA_BITS));
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_BITS - 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic           PAR_ODD  = (ODD_PARITY != 0);

    logic w_clk_lvl;
    logic w_fall;
    logic w_dat;
    logic w_dat_fall;
    logic w_unused;

    ps2_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_clk (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_pin   (ps2_clk),
        .o_level (w_clk_lvl),
        .o_fall  (w_fall)
    );

    ps2_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_dat (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_pin   (ps2_dat),
        .o_level (w_dat),
        .o_fall  (w_dat_fall)
    );

    assign w_unused = w_clk_lvl ^ w_dat_fall;

    ps2_state_e           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_cnt;
    logic                 r_par;
    logic [WDW-1:0]       r_wd;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;

    ps2_state_e           w_state_n;
    logic [DATA_BITS-1:0] w_shift_n;
    logic [CW-1:0]        w_cnt_n;
    logic                 w_par_n;
    logic [WDW-1:0]       w_wd_n;
    logic [DATA_BITS-1:0] w_data_n;
    logic                 w_valid_n;
    logic                 w_perr_n;
    logic                 w_ferr_n;
    logic                 w_ovr_n;
    logic                 w_free;
    logic                 w_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_wd    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
            r_par   <= w_par_n;
            r_wd    <= w_wd_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
            r_perr  <= w_perr_n;
            r_ferr  <= w_ferr_n;
            r_ovr   <= w_ovr_n;
        end
    end

    assign w_free   = !r_valid || rx_ready;
    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign w_expire = (r_state != IDLE) && !w_fall && (r_wd >= WD_LAST);

    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_cnt_n   = r_cnt;
        w_par_n   = r_par;
        w_wd_n    = r_wd;
        w_data_n  = r_data;
        w_valid_n = r_valid && !rx_ready;
        w_perr_n  = 1'b0;
        w_ferr_n  = 1'b0;
        w_ovr_n   = 1'b0;

        if (r_state == IDLE || w_fall) begin
            w_wd_n = '0;
        end else if (r_wd != '1) begin
            w_wd_n = r_wd + 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                if (w_fall && !w_dat) begin
                    w_state_n = DATA;
                    w_cnt_n   = '0;
                    w_shift_n = '0;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shift_n = {w_dat, r_shift[DATA_BITS-1:1]};
                    w_cnt_n   = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_par_n   = w_dat;
                    w_state_n = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_state_n = IDLE;
                    if (!w_dat) begin
                        w_ferr_n = 1'b1;
                    end else if (!parity_ok(32'(r_shift), r_par, PAR_ODD)) begin
                        w_perr_n = 1'b1;
                    end else if (w_free) begin
                        w_data_n  = r_shift;
                        w_valid_n = 1'b1;
                    end else begin
                        w_ovr_n = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_expire) begin
            w_state_n = IDLE;
            w_ferr_n  = 1'b1;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: directed scenarios plus randomized frames.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int DB = 8;
    localparam int TO = 200;
    localparam int HP = 20;

    localparam int EV_BYTE = 1;
    localparam int EV_PERR = 2;
    localparam int EV_FERR = 3;
    localparam int EV_OVR  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ps2_clk = 1'b1;
    logic          ps2_dat = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int q[$];

    ps2_frame_rx #(
        .DATA_BITS      (DB),
        .SYNC_STAGES    (2),
        .ODD_PARITY     (1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic see(input int got);
        int exp;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %0h, expected none", got);
        end else begin
            exp = q.pop_front();
            if (exp != got) begin
                errors++;
                $display("FAIL event: got %0h, expected %0h", got, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) see((EV_BYTE << 8) | int'(rx_data));
            if (parity_err) see(EV_PERR << 8);
            if (frame_err) see(EV_FERR << 8);
            if (overrun) see(EV_OVR << 8);
        end
    end

    // Reference: stop bit dominates, then odd parity over data+parity, then holding register.
    function automatic int model(input logic [DB-1:0] d, input logic par,
                                 input logic stop, input bit held);
        int ones = 0;
        for (int i = 0; i < DB; i++) ones += d[i];
        if (!stop) return EV_FERR << 8;
        if (((ones + par) % 2) != 1) return EV_PERR << 8;
        if (held) return EV_OVR << 8;
        return (EV_BYTE << 8) | int'(d);
    endfunction

    function automatic logic oddp(input logic [DB-1:0] d);
        return ~(^d);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        cyc(HP / 2);
        ps2_clk = 1'b0;
        cyc(HP);
        ps2_clk = 1'b1;
        cyc(HP / 2);
    endtask

    task automatic send(input logic [DB-1:0] d, input logic par,
                        input logic stop, input int nfalls);
        logic [PS2_FRAME_BITS-1:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nfalls; i++) ps2_bit(bits[i]);
        ps2_dat = 1'b1;
        cyc(HP);
    endtask

    task automatic issue(input logic [DB-1:0] d, input logic par, input logic stop);
        q.push_back(model(d, par, stop, 1'b0));
        send(d, par, stop, PS2_FRAME_BITS);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rx_valid"}, int'(rx_valid), 0);
        chk({tag, "_rx_data"}, int'(rx_data), 0);
        chk({tag, "_parity_err"}, int'(parity_err), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [DB-1:0] d;
        int kind;
        int n;

        cyc(3);
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        cyc(5);

        issue(8'h1C, 1'b0, 1'b1);
        chk("clean_busy", int'(busy), 0);

        issue(8'h1C, 1'b1, 1'b1);
        chk("perr_valid", int'(rx_valid), 0);

        issue(8'hF0, 1'b1, 1'b0);
        chk("ferr_valid", int'(rx_valid), 0);

        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        cyc(HP);
        chk("idle_glitch_busy", int'(busy), 0);

        rx_ready = 1'b0;
        send(8'h1C, oddp(8'h1C), 1'b1, PS2_FRAME_BITS);
        chk("ovr_first_valid", int'(rx_valid), 1);
        chk("ovr_first_data", int'(rx_data), 'h1C);
        q.push_back(model(8'hF0, oddp(8'hF0), 1'b1, 1'b1));
        send(8'hF0, oddp(8'hF0), 1'b1, PS2_FRAME_BITS);
        chk("ovr_kept_data", int'(rx_data), 'h1C);
        chk("ovr_kept_valid", int'(rx_valid), 1);
        q.push_back((EV_BYTE << 8) | 'h1C);
        rx_ready = 1'b1;
        cyc(5);
        chk("ovr_drained_valid", int'(rx_valid), 0);
        chk("ovr_queue_empty", q.size(), 0);

        q.push_back(EV_FERR << 8);
        send(8'hF0, 1'b1, 1'b1, 6);
        chk("wd_busy_mid", int'(busy), 1);
        cyc(TO);
        chk("wd_busy_after", int'(busy), 0);
        issue(8'hF0, oddp(8'hF0), 1'b1);

        send(8'h5A, 1'b1, 1'b1, 5);
        reset_n = 1'b0;
        cyc(2);
        chk_idle_outputs("midreset");
        reset_n = 1'b1;
        cyc(5);
        issue(8'h5A, 1'b1, 1'b1);
        chk("after_reset_data", int'(rx_data), 'h5A);

        for (int it = 0; it < 24; it++) begin
            d = DB'($urandom);
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                issue(d, oddp(d), 1'b1);
            end else if (kind == 6) begin
                issue(d, ~oddp(d), 1'b1);
            end else if (kind == 7) begin
                issue(d, 1'($urandom), 1'b0);
            end else if (kind == 8) begin
                n = $urandom_range(1, PS2_FRAME_BITS - 1);
                q.push_back(EV_FERR << 8);
                send(d, oddp(d), 1'b1, n);
                cyc(TO);
            end else begin
                ps2_bit(1'b1);
                ps2_dat = 1'b1;
            end
            cyc($urandom_range(0, 30));
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) cyc(1);
        chk("final_queue_empty", q.size(), 0);
        chk("final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
